// File: rtl/rom16x1_burst_reader.sv
// rtl/rom16x1_burst_reader.sv - burst sequencer reading 1..16 bits out of a ROM16X1A LUT-ROM
//
// Purpose:
//   On START (sampled only while idle) walks the ROM address from SADDR for
//   LEN+1 consecutive locations (4-bit wrap), holds each address RD_LAT
//   cycles, samples DO0 into DOUT[index] and then presents the packed word
//   on a valid/ready port until the consumer accepts it.
//
// Ports:
//   CK        clock, all state updates on the rising edge
//   RSTN      synchronous active-low reset, highest priority
//   START     burst request, ignored while BUSY
//   SADDR[3:0] start address, latched with START
//   LEN[3:0]  number of bits minus 1, latched with START
//   BUSY      high in every state except IDLE
//   AD0..AD3  ROM address pins (AD0 = LSB), driven from a register
//   DO0       ROM data output, sampled unmasked
//   DOUT[15:0] packed result, bits above LEN read as 0
//   DVALID    DOUT valid
//   DREADY    consumer accepts DOUT

module rom16x1_burst_reader #(
  parameter int RD_LAT = 1
) (
  input  logic        CK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [3:0]  SADDR,
  input  logic [3:0]  LEN,
  output logic        BUSY,
  output logic        AD0,
  output logic        AD1,
  output logic        AD2,
  output logic        AD3,
  input  logic        DO0,
  output logic [15:0] DOUT,
  output logic        DVALID,
  input  logic        DREADY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Last wait count before DO0 is sampled; RD_LAT is limited to 1..3.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t      state_q;
  logic [3:0]  addr_q;
  logic [3:0]  idx_q;
  logic [3:0]  rem_q;
  logic [1:0]  wait_q;
  logic [15:0] dout_q;
  logic        busy_q;
  logic        dvalid_q;

  logic [3:0]  addr_d;
  logic [3:0]  idx_d;
  logic [3:0]  rem_d;
  logic        sample_now;

  // Step values used when one ROM bit has been captured; all wrap silently.
  always_comb begin
    addr_d     = addr_q + 4'd1;
    idx_d      = idx_q + 4'd1;
    rem_d      = rem_q - 4'd1;
    sample_now = (wait_q == WAIT_LAST);
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      addr_q   <= 4'd0;
      idx_q    <= 4'd0;
      rem_q    <= 4'd0;
      wait_q   <= 2'd0;
      dout_q   <= 16'h0000;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            addr_q  <= SADDR;
            rem_q   <= LEN;
            idx_q   <= 4'd0;
            wait_q  <= 2'd0;
            dout_q  <= 16'h0000;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (sample_now) begin
            // Address has been stable RD_LAT cycles: capture and advance.
            dout_q[idx_q] <= DO0;
            wait_q        <= 2'd0;
            if (rem_q == 4'd0) begin
              // Final bit: address stays put, result goes valid.
              dvalid_q <= 1'b1;
              state_q  <= ST_HOLD;
            end else begin
              addr_q <= addr_d;
              idx_q  <= idx_d;
              rem_q  <= rem_d;
            end
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end

        ST_HOLD: begin
          // START is deliberately not looked at here, even on the handshake edge.
          if (DREADY) begin
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        default: begin
          dvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DVALID = dvalid_q;
  assign DOUT   = dout_q;
  assign AD0    = addr_q[0];
  assign AD1    = addr_q[1];
  assign AD2    = addr_q[2];
  assign AD3    = addr_q[3];

endmodule

// File: tb/tb_rom16x1_burst_reader.sv
// tb/tb_rom16x1_burst_reader.sv - directed bench for rom16x1_burst_reader at RD_LAT 1, 2 and 3

module tb_rom16x1_burst_reader;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rstn;
  logic        dready;
  logic [3:0]  saddr;
  logic [3:0]  len;
  logic        start1, start2, start3;
  logic [15:0] rom;

  logic        busy1, dv1, a1_0, a1_1, a1_2, a1_3, do1;
  logic        busy2, dv2, a2_0, a2_1, a2_2, a2_3, do2;
  logic        busy3, dv3, a3_0, a3_1, a3_2, a3_3, do3;
  logic [15:0] dout1, dout2, dout3;
  logic [3:0]  ad1, ad2, ad3;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural ROM16X1A, initval 16'hA5C3
  assign ad1 = {a1_3, a1_2, a1_1, a1_0};
  assign ad2 = {a2_3, a2_2, a2_1, a2_0};
  assign ad3 = {a3_3, a3_2, a3_1, a3_0};
  assign do1 = rom[ad1];
  assign do2 = rom[ad2];
  assign do3 = rom[ad3];

  rom16x1_burst_reader #(.RD_LAT(1)) dut1 (
    .CK(ck), .RSTN(rstn), .START(start1), .SADDR(saddr), .LEN(len), .BUSY(busy1),
    .AD0(a1_0), .AD1(a1_1), .AD2(a1_2), .AD3(a1_3), .DO0(do1),
    .DOUT(dout1), .DVALID(dv1), .DREADY(dready)
  );

  rom16x1_burst_reader #(.RD_LAT(2)) dut2 (
    .CK(ck), .RSTN(rstn), .START(start2), .SADDR(saddr), .LEN(len), .BUSY(busy2),
    .AD0(a2_0), .AD1(a2_1), .AD2(a2_2), .AD3(a2_3), .DO0(do2),
    .DOUT(dout2), .DVALID(dv2), .DREADY(dready)
  );

  rom16x1_burst_reader #(.RD_LAT(3)) dut3 (
    .CK(ck), .RSTN(rstn), .START(start3), .SADDR(saddr), .LEN(len), .BUSY(busy3),
    .AD0(a3_0), .AD1(a3_1), .AD2(a3_2), .AD3(a3_3), .DO0(do3),
    .DOUT(dout3), .DVALID(dv3), .DREADY(dready)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic saw_valid;
    rom    = 16'hA5C3;
    rstn   = 1'b0;
    dready = 1'b0;
    saddr  = 4'd0;
    len    = 4'd0;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;

    // Reset state
    check("rst_busy1", 16'(busy1), 16'h0);
    check("rst_dv1", 16'(dv1), 16'h0);
    check("rst_dout1", dout1, 16'h0000);
    check("rst_ad1", 16'(ad1), 16'h0);
    check("rst_ad3", 16'(ad3), 16'h0);
    check("rst_busy3", 16'(busy3), 16'h0);

    // 1. Full read, RD_LAT=1
    saddr = 4'd0; len = 4'd15; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("full_busy", 16'(busy1), 16'h1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("full_ad%0d", k), 16'(ad1), 16'(k));
      check($sformatf("full_nodv%0d", k), 16'(dv1), 16'h0);
      tick();
    end
    check("full_dv", 16'(dv1), 16'h1);
    check("full_dout", dout1, 16'hA5C3);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("full_done_dv", 16'(dv1), 16'h0);
    check("full_done_busy", 16'(busy1), 16'h0);
    check("full_keep_dout", dout1, 16'hA5C3);

    // 2. Wrap-around
    saddr = 4'd14; len = 4'd3; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_ad%0d", k), 16'(ad1), 16'((14 + k) % 16));
      tick();
    end
    check("wrap_dv", 16'(dv1), 16'h1);
    check("wrap_dout", dout1, 16'h000E);
    dready = 1'b1;
    tick();
    dready = 1'b0;

    // 3a. Single bit, RD_LAT=2
    saddr = 4'd6; len = 4'd0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("single_ad_c0", 16'(ad2), 16'h6);
    check("single_dv_c0", 16'(dv2), 16'h0);
    tick();
    check("single_ad_c1", 16'(ad2), 16'h6);
    check("single_dv_c1", 16'(dv2), 16'h0);
    tick();
    check("single_dv", 16'(dv2), 16'h1);
    check("single_dout", dout2, 16'h0001);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("single_done_busy", 16'(busy2), 16'h0);

    // 3b. RD_LAT=3, SADDR=15, LEN=1
    saddr = 4'd15; len = 4'd1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("lat3_ad%0d", k), 16'(ad3), (k < 3) ? 16'hF : 16'h0);
      check($sformatf("lat3_nodv%0d", k), 16'(dv3), 16'h0);
      tick();
    end
    check("lat3_dv", 16'(dv3), 16'h1);
    check("lat3_dout", dout3, 16'h0003);
    dready = 1'b1;
    tick();
    dready = 1'b0;

    // 4. Backpressure with ignored STARTs
    saddr = 4'd0; len = 4'd7; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (8) tick();
    check("bp_dv", 16'(dv1), 16'h1);
    check("bp_dout", dout1, 16'h00C3);
    for (int i = 0; i < 5; i++) begin
      start1 = (i % 2 == 0);
      saddr  = 4'd9;
      tick();
      check($sformatf("bp_hold_dv%0d", i), 16'(dv1), 16'h1);
      check($sformatf("bp_hold_dout%0d", i), dout1, 16'h00C3);
      check($sformatf("bp_hold_ad%0d", i), 16'(ad1), 16'h7);
    end
    start1 = 1'b1;
    dready = 1'b1;
    tick();
    check("bp_hs_dv", 16'(dv1), 16'h0);
    check("bp_hs_busy", 16'(busy1), 16'h0);
    check("bp_hs_dout", dout1, 16'h00C3);
    start1 = 1'b0;
    dready = 1'b0;
    tick();
    check("bp_start_ignored", 16'(busy1), 16'h0);

    // 5. Reset mid-burst
    saddr = 4'd0; len = 4'd15; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check("rstmid_ad", 16'(ad1), 16'h2);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rstmid_busy", 16'(busy1), 16'h0);
    check("rstmid_dv", 16'(dv1), 16'h0);
    check("rstmid_dout", dout1, 16'h0000);
    check("rstmid_ad0", 16'(ad1), 16'h0);
    saw_valid = 1'b0;
    repeat (20) begin
      tick();
      if (dv1 === 1'b1) saw_valid = 1'b1;
    end
    check("rstmid_no_dv", 16'(saw_valid), 16'h0);
    saddr = 4'd8; len = 4'd7; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("fresh_ad", 16'(ad1), 16'h8);
    repeat (8) tick();
    check("fresh_dv", 16'(dv1), 16'h1);
    check("fresh_dout", dout1, 16'h00A5);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("fresh_done", 16'(busy1), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
